multicycle_main_ctrl: RTL and testbench

- Main control FSM for the multicycle RV32I datapath. It sits directly upstream of the ALU control decoder and drives its 2-bit ALUOp.
- It sequences fetch, decode, execute, memory and writeback for lw, sw, R-type, I-type ALU, beq and jal.
- It produces all datapath enables and mux selects.

---
 rtl/multicycle_main_ctrl.sv | 173 +++++++++++++++++
 tb/tb_multicycle_main_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_main_ctrl.sv
// Main control FSM for the multicycle RV32I datapath (lw, sw, R-type,
// I-type ALU, beq, jal). Drives all datapath enables, mux selects and the
// 2-bit ALUOp consumed by the ALU control decoder.
// Build option: define MAIN_CTRL_ILLEGAL_TRAP_EN to trap unrecognised opcodes
// in an absorbing ILLEGAL state; otherwise they execute as a 2-cycle NOP.
module multicycle_main_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic       zero,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] imm_src,
    output logic       reg_write,
    output logic [1:0] alu_op,
    output logic [3:0] fsm_state
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        ALUWB    = 4'd7,
        EXECUTEI = 4'd8,
        JAL      = 4'd9,
        BEQ      = 4'd10,
        ILLEGAL  = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    state_t state;
    state_t state_next;
    logic   pc_update;
    logic   branch;

    // State register; async reset aborts any instruction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and Moore output decode.
    always_comb begin
        state_next = state;
        pc_update  = 1'b0;
        branch     = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        reg_write  = 1'b0;
        alu_op     = 2'b00;
        unique case (state)
            FETCH: begin
                ir_write   = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                pc_update  = 1'b1;
                state_next = DECODE;
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (op)
                    OP_LW, OP_SW: state_next = MEMADR;
                    OP_R:         state_next = EXECUTER;
                    OP_I:         state_next = EXECUTEI;
                    OP_JAL:       state_next = JAL;
                    OP_BEQ:       state_next = BEQ;
`ifdef MAIN_CTRL_ILLEGAL_TRAP_EN
                    default:      state_next = ILLEGAL;
`else
                    default:      state_next = FETCH;
`endif
                endcase
            end
            MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                if (op == OP_LW) begin
                    state_next = MEMREAD;
                end else if (op == OP_SW) begin
                    state_next = MEMWRITE;
                end else begin
                    state_next = FETCH;
                end
            end
            MEMREAD: begin
                adr_src    = 1'b1;
                state_next = MEMWB;
            end
            MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                state_next = FETCH;
            end
            MEMWRITE: begin
                adr_src    = 1'b1;
                mem_write  = 1'b1;
                state_next = FETCH;
            end
            EXECUTER: begin
                alu_src_a  = 2'b10;
                alu_op     = 2'b10;
                state_next = ALUWB;
            end
            EXECUTEI: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                alu_op     = 2'b10;
                state_next = ALUWB;
            end
            ALUWB: begin
                reg_write  = 1'b1;
                state_next = FETCH;
            end
            JAL: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                pc_update  = 1'b1;
                state_next = ALUWB;
            end
            BEQ: begin
                alu_src_a  = 2'b10;
                alu_op     = 2'b01;
                branch     = 1'b1;
                state_next = FETCH;
            end
            ILLEGAL: begin
`ifdef MAIN_CTRL_ILLEGAL_TRAP_EN
                state_next = ILLEGAL;
`else
                state_next = FETCH;
`endif
            end
            default: state_next = FETCH;
        endcase
    end

    // Immediate format follows the opcode directly, independent of state.
    always_comb begin
        case (op)
            OP_SW:   imm_src = 2'b01;
            OP_BEQ:  imm_src = 2'b10;
            OP_JAL:  imm_src = 2'b11;
            default: imm_src = 2'b00;
        endcase
    end

    assign pc_write  = pc_update | (branch & zero);
    assign fsm_state = state;

endmodule

// File: tb/tb_multicycle_main_ctrl.sv
// Self-checking bench for multicycle_main_ctrl: directed per-instruction
// scenarios plus randomized opcode/zero streams against a reference model.
module tb_multicycle_main_ctrl;

    logic       clk;
    logic       rst;
    logic [6:0] op;
    logic       zero;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_src;
    logic       reg_write;
    logic [1:0] alu_op;
    logic [3:0] fsm_state;

    int checks = 0;
    int errors = 0;

    multicycle_main_ctrl dut (
        .clk(clk), .rst(rst), .op(op), .zero(zero),
        .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
        .ir_write(ir_write), .result_src(result_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .imm_src(imm_src), .reg_write(reg_write),
        .alu_op(alu_op), .fsm_state(fsm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed view: {pc_write, adr_src, mem_write, ir_write, result_src,
    //               alu_src_a, alu_src_b, imm_src, reg_write, alu_op}
    wire [14:0] outs = {pc_write, adr_src, mem_write, ir_write, result_src,
                        alu_src_a, alu_src_b, imm_src, reg_write, alu_op};

    function automatic bit is_known(input logic [6:0] o);
        return o == 7'b0000011 || o == 7'b0100011 || o == 7'b0110011 ||
               o == 7'b0010011 || o == 7'b1101111 || o == 7'b1100011;
    endfunction

    // Reference: expected control word for a given state, opcode and zero flag.
    function automatic logic [14:0] exp_out(input int st, input logic [6:0] o, input logic z);
        logic pcu, br, adr, mw, irw, rw;
        logic [1:0] rs, sa, sb, imm, aop;
        {pcu, br, adr, mw, irw, rw} = 6'b0;
        {rs, sa, sb, aop} = 8'b0;
        case (st)
            0:  begin irw = 1; sb = 2; rs = 2; pcu = 1; end
            1:  begin sa = 1; sb = 1; end
            2:  begin sa = 2; sb = 1; end
            3:  adr = 1;
            4:  begin rs = 1; rw = 1; end
            5:  begin adr = 1; mw = 1; end
            6:  begin sa = 2; aop = 2; end
            7:  rw = 1;
            8:  begin sa = 2; sb = 1; aop = 2; end
            9:  begin sa = 1; sb = 2; pcu = 1; end
            10: begin sa = 2; aop = 1; br = 1; end
            default: ;
        endcase
        if (o == 7'b0100011)      imm = 2'b01;
        else if (o == 7'b1100011) imm = 2'b10;
        else if (o == 7'b1101111) imm = 2'b11;
        else                      imm = 2'b00;
        return {pcu | (br & z), adr, mw, irw, rs, sa, sb, imm, rw, aop};
    endfunction

    // Reference: state walk for one instruction, starting at FETCH.
    function automatic void exp_seq(input logic [6:0] o, output int q[$]);
        q = {0, 1};
        case (o)
            7'b0000011: q = {q, 2, 3, 4};
            7'b0100011: q = {q, 2, 5};
            7'b0110011: q = {q, 6, 7};
            7'b0010011: q = {q, 8, 7};
            7'b1101111: q = {q, 9, 7};
            7'b1100011: q = {q, 10};
            default: ;
        endcase
    endfunction

    // Runs one instruction from FETCH; entered and left just after a posedge.
    task automatic exec_instr(input string name, input logic [6:0] o, input int zmode);
        int q[$];
        exp_seq(o, q);
        op = o;
        foreach (q[i]) begin
            zero = (zmode == 2) ? 1'($urandom) : 1'(zmode);
            #1;
            checks++;
            if (fsm_state !== 4'(q[i])) begin
                errors++;
                $display("FAIL %s state[%0d]: got %0d want %0d", name, i, fsm_state, q[i]);
            end
            checks++;
            if (outs !== exp_out(q[i], o, zero)) begin
                errors++;
                $display("FAIL %s outs[%0d] st=%0d: got %h want %h", name, i, q[i], outs, exp_out(q[i], o, zero));
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (fsm_state !== 4'd0) begin
            errors++;
            $display("FAIL %s return: got %0d want 0", name, fsm_state);
        end
    endtask

    task automatic test_reset();
        rst = 0; op = 7'b0000011; zero = 0;
        #2 rst = 1;
        #1;
        checks++;
        if (fsm_state !== 4'd0 || outs !== exp_out(0, op, zero)) begin
            errors++;
            $display("FAIL reset: got st=%0d outs=%h want st=0 outs=%h", fsm_state, outs, exp_out(0, op, zero));
        end
        @(posedge clk);
        #1 rst = 0;
    endtask

    task automatic test_lw();       exec_instr("lw", 7'b0000011, 2);    endtask
    task automatic test_rtype();    exec_instr("rtype", 7'b0110011, 2); endtask
    task automatic test_itype();    exec_instr("itype", 7'b0010011, 2); endtask
    task automatic test_sw();       exec_instr("sw", 7'b0100011, 2);    endtask
    task automatic test_jal();      exec_instr("jal", 7'b1101111, 2);   endtask
    task automatic test_beq();
        exec_instr("beq_taken", 7'b1100011, 1);
        exec_instr("beq_not_taken", 7'b1100011, 0);
    endtask

    task automatic test_illegal();
`ifdef MAIN_CTRL_ILLEGAL_TRAP_EN
        op = 7'b1111111;
        zero = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            zero = 1'($urandom);
            #1;
            checks++;
            if (fsm_state !== 4'd11 || outs !== 15'd0) begin
                errors++;
                $display("FAIL illegal_hold[%0d]: got st=%0d outs=%h want st=11 outs=0", i, fsm_state, outs);
            end
            @(posedge clk); #1;
        end
        #2 rst = 1;
        #1;
        checks++;
        if (fsm_state !== 4'd0 || outs !== exp_out(0, op, zero)) begin
            errors++;
            $display("FAIL illegal_rst: got st=%0d outs=%h want st=0 outs=%h", fsm_state, outs, exp_out(0, op, zero));
        end
        @(posedge clk);
        #1 rst = 0;
`else
        exec_instr("illegal_nop", 7'b1111111, 2);
`endif
    endtask

    task automatic test_mid_reset();
        op = 7'b0000011;
        zero = 0;
        repeat (3) begin @(posedge clk); #1; end
        checks++;
        if (fsm_state !== 4'd3) begin
            errors++;
            $display("FAIL mid_reset_pre: got %0d want 3", fsm_state);
        end
        #2 rst = 1;
        #1;
        checks++;
        if (fsm_state !== 4'd0 || outs !== exp_out(0, op, zero)) begin
            errors++;
            $display("FAIL mid_reset: got st=%0d outs=%h want st=0 outs=%h", fsm_state, outs, exp_out(0, op, zero));
        end
        @(posedge clk);
        #1 rst = 0;
    endtask

    task automatic test_random();
        logic [6:0] legal[6] = '{7'b0000011, 7'b0100011, 7'b0110011,
                                  7'b0010011, 7'b1101111, 7'b1100011};
        logic [6:0] o;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) != 0) begin
                o = legal[$urandom_range(0, 5)];
            end else begin
                o = 7'($urandom);
`ifdef MAIN_CTRL_ILLEGAL_TRAP_EN
                if (!is_known(o)) o = legal[$urandom_range(0, 5)];
`endif
            end
            exec_instr("random", o, 2);
        end
    endtask

    task automatic test_back_to_back();
        exec_instr("b2b_beq", 7'b1100011, 1);
        exec_instr("b2b_sw", 7'b0100011, 2);
        exec_instr("b2b_lw", 7'b0000011, 2);
        exec_instr("b2b_jal", 7'b1101111, 2);
    endtask

    initial begin
        test_reset();
        test_lw();
        test_rtype();
        test_itype();
        test_beq();
        test_sw();
        test_jal();
        test_back_to_back();
        test_mid_reset();
        test_random();
        test_illegal();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
